// File: rtl/alu_mem_demux_pkg.sv
// Shared definitions for the ALU / memory operand demultiplexer.
// Default widths and the branch-select encoding used on dmx.
package alu_mem_demux_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 8;

  typedef enum logic {
    SEL_ALU = 1'b0,
    SEL_MEM = 1'b1
  } sel_e;

endpackage

// File: rtl/alu_mem_demux_if.sv
// Bus between the first pipeline buffer / controller and the demux.
// master: the producer side (drives select, valid and data, observes results).
// slave:  the demux itself.
interface alu_mem_demux_if #(
  parameter int DATA_W = alu_mem_demux_pkg::DATA_W,
  parameter int CNT_W  = alu_mem_demux_pkg::CNT_W
) ();
  import alu_mem_demux_pkg::*;

  sel_e              dmx;
  logic              in_valid;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] out_alu;
  logic              out_alu_valid;
  logic [DATA_W-1:0] out_mem;
  logic              out_mem_valid;
  logic [CNT_W-1:0]  alu_count;
  logic [CNT_W-1:0]  mem_count;

  modport master (
    output dmx, in_valid, data_in,
    input  out_alu, out_alu_valid, out_mem, out_mem_valid, alu_count, mem_count
  );

  modport slave (
    input  dmx, in_valid, data_in,
    output out_alu, out_alu_valid, out_mem, out_mem_valid, alu_count, mem_count
  );

endinterface

// File: rtl/alu_mem_demux_sat_counter.sv
// Saturating up-counter: counts inc pulses, sticks at all-ones, never wraps.
module sat_counter #(
  parameter int CNT_W = alu_mem_demux_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_reg;

  // Increment on request unless already saturated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (inc && (count_reg != {CNT_W{1'b1}})) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/alu_mem_demux.sv
// Registered 1-to-2 demux routing buffered operand A to the ALU or the
// data-memory address path, with per-branch valid strobes and saturating
// transfer counters.
// Optional feature macro: ALU_MEM_DEMUX_HOLD_EN -- when defined the
// unselected data output keeps its last value; otherwise any data output
// whose valid goes low is cleared to 0.
module alu_mem_demux #(
  parameter int DATA_W = alu_mem_demux_pkg::DATA_W,
  parameter int CNT_W  = alu_mem_demux_pkg::CNT_W
) (
  input  logic          clk,
  input  logic          rst,
  alu_mem_demux_if.slave bus
);
  import alu_mem_demux_pkg::*;

  logic [DATA_W-1:0] out_alu_reg;
  logic [DATA_W-1:0] out_mem_reg;
  logic              alu_valid_reg;
  logic              mem_valid_reg;

  // dmx only matters when qualified by in_valid.
  logic take_alu;
  logic take_mem;
  assign take_alu = bus.in_valid && (bus.dmx == SEL_ALU);
  assign take_mem = bus.in_valid && (bus.dmx == SEL_MEM);

  // Valid strobes: at most one branch can be selected per transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_valid_reg <= 1'b0;
      mem_valid_reg <= 1'b0;
    end else begin
      alu_valid_reg <= take_alu;
      mem_valid_reg <= take_mem;
    end
  end

`ifdef ALU_MEM_DEMUX_HOLD_EN
  // Data registers load only on their own transfer; stale value otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_alu_reg <= '0;
      out_mem_reg <= '0;
    end else begin
      if (take_alu) out_alu_reg <= bus.data_in;
      if (take_mem) out_mem_reg <= bus.data_in;
    end
  end
`else
  // Data registers are zero whenever their valid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_alu_reg <= '0;
      out_mem_reg <= '0;
    end else begin
      out_alu_reg <= take_alu ? bus.data_in : '0;
      out_mem_reg <= take_mem ? bus.data_in : '0;
    end
  end
`endif

  sat_counter #(.CNT_W(CNT_W)) u_alu_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (take_alu),
    .count (bus.alu_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_mem_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (take_mem),
    .count (bus.mem_count)
  );

  assign bus.out_alu       = out_alu_reg;
  assign bus.out_mem       = out_mem_reg;
  assign bus.out_alu_valid = alu_valid_reg;
  assign bus.out_mem_valid = mem_valid_reg;

endmodule

// File: tb/tb_alu_mem_demux.sv
// Directed bench for alu_mem_demux; works with or without ALU_MEM_DEMUX_HOLD_EN.
module tb_alu_mem_demux;
  import alu_mem_demux_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  alu_mem_demux_if #(.DATA_W(32), .CNT_W(8)) bus ();

  alu_mem_demux #(.DATA_W(32), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input sel_e s, input logic [31:0] d);
    bus.in_valid = v;
    bus.dmx      = s;
    bus.data_in  = d;
  endtask

  task automatic check_all(input string tag, input logic [31:0] alu, input logic av,
                           input logic [31:0] mem, input logic mv,
                           input logic [7:0] ac, input logic [7:0] mc);
    check({tag, ".out_alu"},   bus.out_alu, alu);
    check({tag, ".alu_valid"}, {31'd0, bus.out_alu_valid}, {31'd0, av});
    check({tag, ".out_mem"},   bus.out_mem, mem);
    check({tag, ".mem_valid"}, {31'd0, bus.out_mem_valid}, {31'd0, mv});
    check({tag, ".alu_count"}, {24'd0, bus.alu_count}, {24'd0, ac});
    check({tag, ".mem_count"}, {24'd0, bus.mem_count}, {24'd0, mc});
  endtask

  // Expected stale value of an unselected data output after its valid drops.
  function automatic logic [31:0] stale(input logic [31:0] last);
`ifdef ALU_MEM_DEMUX_HOLD_EN
    return last;
`else
    return 32'd0;
`endif
  endfunction

  logic [31:0] exp_alu;
  logic [31:0] exp_mem;
  logic [31:0] d;

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    drive(1'b0, SEL_ALU, 32'd0);
    tick();
    tick();
    check_all("reset", 32'd0, 1'b0, 32'd0, 1'b0, 8'd0, 8'd0);
    rst = 1'b0;

    // ALU route: first transfer after reset release.
    drive(1'b1, SEL_ALU, 32'h0000_00A5);
    tick();
    check_all("alu_route", 32'h0000_00A5, 1'b1, 32'd0, 1'b0, 8'd1, 8'd0);

    // Asynchronous reset mid-cycle with a memory transfer pending.
    drive(1'b1, SEL_MEM, 32'h1234_5678);
    #2 rst = 1'b1;
    #1;
    check_all("async_rst", 32'd0, 1'b0, 32'd0, 1'b0, 8'd0, 8'd0);
    tick();
    drive(1'b0, SEL_ALU, 32'd0);
    rst = 1'b0;
    tick();
    check_all("rst_lost", 32'd0, 1'b0, 32'd0, 1'b0, 8'd0, 8'd0);

    // MEM route, then idle.
    drive(1'b1, SEL_MEM, 32'hDEAD_BEEF);
    tick();
    check_all("mem_route", 32'd0, 1'b0, 32'hDEAD_BEEF, 1'b1, 8'd0, 8'd1);
    drive(1'b0, SEL_MEM, 32'h5555_AAAA);
    tick();
    exp_mem = stale(32'hDEAD_BEEF);
    check_all("mem_idle", 32'd0, 1'b0, exp_mem, 1'b0, 8'd0, 8'd1);

    // Select toggling without in_valid has no effect.
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, (i % 2 == 0) ? SEL_ALU : SEL_MEM, 32'hFFFF_0000 + i);
      tick();
      check_all($sformatf("nosel%0d", i), 32'd0, 1'b0, exp_mem, 1'b0, 8'd0, 8'd1);
    end

    // Alternating select over 6 transfers from a clean reset.
    rst = 1'b1;
    #2 rst = 1'b0;
    exp_alu = 32'd0;
    exp_mem = 32'd0;
    for (int i = 0; i < 6; i++) begin
      d = 32'h1000_0000 + 32'(i);
      drive(1'b1, (i % 2 == 0) ? SEL_ALU : SEL_MEM, d);
      tick();
      if (i % 2 == 0) begin
        exp_alu = d;
        exp_mem = stale(exp_mem);
        check_all($sformatf("alt%0d", i), exp_alu, 1'b1, exp_mem, 1'b0,
                  8'((i / 2) + 1), 8'(i / 2));
      end else begin
        exp_mem = d;
        exp_alu = stale(exp_alu);
        check_all($sformatf("alt%0d", i), exp_alu, 1'b0, exp_mem, 1'b1,
                  8'((i / 2) + 1), 8'((i / 2) + 1));
      end
    end

    // Saturation: 300 ALU transfers from the count of 3.
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, SEL_ALU, 32'(i));
      tick();
      if (i == 250) check("sat_254", {24'd0, bus.alu_count}, 32'd254);
      if (i == 251) check("sat_255", {24'd0, bus.alu_count}, 32'd255);
    end
    drive(1'b0, SEL_ALU, 32'd0);
    tick();
    check_all("sat_end", stale(32'd299), 1'b0, stale(exp_mem), 1'b0, 8'd255, 8'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
